fetch_queue: RTL and testbench

Prefetching instruction-fetch front end for the five-stage MIPS pipeline. It owns the program counter, issues pipelined reads to instruction memory, and buffers returned instructions with their PC+4 in a small FIFO. It feeds the IF/ID pipeline register with a valid/ready handshake, so decode stalls no longer freeze fetch. Branch and jump redirects from the MEM stage flush the queue and any in-flight read.

---
 rtl/fetch_pkg.sv | 10 +
 rtl/fq_ring.sv | 67 ++++++
 rtl/fetch_queue.sv | 108 ++++++++++
 tb/tb_fetch_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch queue.
package fetch_pkg;
  localparam int          FQ_DEPTH_DEFAULT = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } fq_entry_t;
endpackage

// File: rtl/fq_ring.sv
// Ring buffer of fetched entries: push at wr_ptr, pop at rd_ptr, flush clears pointers.
module fq_ring
  import fetch_pkg::*;
#(
  parameter  int DEPTH = FQ_DEPTH_DEFAULT,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fq_entry_t     push_data,
  input  logic          pop,
  output fq_entry_t     head,
  output logic [CW-1:0] count
);
  fq_entry_t     mem_q [DEPTH];
  fq_entry_t     mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && count_q == CW'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// Prefetching IF front end: owns the PC, issues imem reads, queues {instr, pc+4}.
// Define FETCH_QUEUE_PERF_EN to build the fetched/flush performance counters.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = FQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushes
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          inflight_q, inflight_d;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          issue, push, pop;
  fq_entry_t     head, push_data;

  // Credit counts only registered state; a pop this cycle frees a slot next cycle.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign issue = !Rst && !redirect_valid && (occ < (CW+1)'(DEPTH));

  assign push      = imem_rvalid && inflight_q && !redirect_valid;
  assign push_data = '{instr: imem_rdata, pc4: addr_q + 32'd4};
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;

  always_comb begin
    pc_d       = pc_q;
    addr_d     = addr_q;
    inflight_d = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d   = pc_q + 32'd4;
      addr_d = pc_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q       <= RESET_PC;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
    end
  end

  fq_ring #(.DEPTH(DEPTH)) u_ring (
    .clk       (Clk),
    .rst       (Rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign out_instr = head.instr;
  assign out_pc4   = head.pc4;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q + {31'b0, pop};
    perf_flushes_d = perf_flushes_q + {31'b0, redirect_valid};
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      perf_fetched_q <= '0;
      perf_flushes_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushes_q <= perf_flushes_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushes = perf_flushes_q;
`else
  assign perf_fetched = '0;
  assign perf_flushes = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory model answers each request next cycle with its address.
module tb_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCH_QUEUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushes;

  int n_chk  = 0;
  int n_pass = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc4        (out_pc4),
    .perf_fetched   (perf_fetched),
    .perf_flushes   (perf_flushes)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // End the current cycle; the memory answers the request seen in it.
  task automatic step();
    logic        req_c;
    logic [31:0] addr_c;
    req_c  = imem_req;
    addr_c = imem_addr;
    @(posedge Clk);
    #1;
    imem_rvalid = req_c;
    imem_rdata  = addr_c;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] instr);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, instr);
    chk({tag, "_pc4"}, out_pc4, instr + 32'd4);
  endtask

  initial begin
    Rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
    step(); step();
    #1;
    chk("rst_req",   {31'b0, imem_req},  32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc4",   out_pc4,   32'd0);
    chk("rst_pfetch", perf_fetched, 32'd0);
    chk("rst_pflush", perf_flushes, 32'd0);

    // Free run: request at 0 in cycle 1, head in cycle 3.
    Rst = 1'b0; #1;
    chk("c1_req",  {31'b0, imem_req}, 32'd1);
    chk("c1_addr", imem_addr, 32'd0);
    step(); #1;
    chk("c2_valid", {31'b0, out_valid}, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      #1; chk_head("run", 32'(4 * i)); step();
    end

    // Redirect with out_ready high and a response returning: no pop, no push.
    redirect_valid = 1'b1; redirect_pc = 32'h0; #1;
    chk("rd1_valid", {31'b0, out_valid}, 32'd0);
    chk("rd1_req",   {31'b0, imem_req},  32'd0);
    step(); redirect_valid = 1'b0; #1;
    chk("rd1_nopush", {31'b0, out_valid}, 32'd0);
    chk("rd1_req2",   {31'b0, imem_req},  32'd1);
    chk("rd1_addr",   imem_addr, 32'd0);
    chk("rd1_pflush", perf_flushes, PERF ? 32'd1 : 32'd0);
    chk("rd1_pfetch", perf_fetched, PERF ? 32'd3 : 32'd0);
    step(); step();
    for (int i = 0; i < 4; i++) begin
      #1; chk_head("rerun", 32'(4 * i)); step();
    end

    // Backpressure for 10 cycles with head at 16.
    out_ready = 1'b0;
    #1; chk("bp_req0", {31'b0, imem_req}, 32'd1); step();
    #1; chk("bp_req1", {31'b0, imem_req}, 32'd1); step();
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("bp_stop", {31'b0, imem_req}, 32'd0);
      chk_head("bp_hold", 32'd16);
      step();
    end
    out_ready = 1'b1; #1;
    chk("rel_nocredit", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk_head("rel", 32'(16 + 4 * i)); step(); #1;
    end

    // Fill to three entries plus one read in flight, then redirect.
    out_ready = 1'b0; step(); #1;
    chk("full_req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100; #1;
    chk("rd2_valid", {31'b0, out_valid}, 32'd0);
    chk("rd2_req",   {31'b0, imem_req},  32'd0);
    step(); redirect_valid = 1'b0; out_ready = 1'b1; #1;
    chk("rd2_stale",  {31'b0, out_valid}, 32'd0);
    chk("rd2_req2",   {31'b0, imem_req},  32'd1);
    chk("rd2_addr",   imem_addr, 32'h100);
    chk("rd2_pflush", perf_flushes, PERF ? 32'd2 : 32'd0);
    chk("rd2_pfetch", perf_fetched, PERF ? 32'd13 : 32'd0);
    step(); step(); #1;
    chk_head("rd2_first", 32'h100);
    step();

    // Reset for one cycle with a read pending; a stray rvalid follows.
    step();
    Rst = 1'b1; step(); Rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #1;
    chk("mr_valid",  {31'b0, out_valid}, 32'd0);
    chk("mr_instr",  out_instr, 32'd0);
    chk("mr_pc4",    out_pc4,   32'd0);
    chk("mr_pfetch", perf_fetched, 32'd0);
    chk("mr_pflush", perf_flushes, 32'd0);
    chk("mr_req",    {31'b0, imem_req}, 32'd1);
    chk("mr_addr",   imem_addr, 32'd0);
    step(); #1;
    chk("mr_stray", {31'b0, out_valid}, 32'd0);
    step(); #1;
    chk_head("mr_first", 32'd0);
    step();

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0; #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    step(); #1;
    chk("wr_req",  {31'b0, imem_req}, 32'd1);
    chk("wr_next", imem_addr, 32'd0);
    step(); #1;
    chk("wr_valid", {31'b0, out_valid}, 32'd1);
    chk("wr_instr", out_instr, 32'hFFFF_FFFC);
    chk("wr_pc4",   out_pc4,   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
